// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port sram arbiter.
// Port ids, FSM encoding and the word-alignment mask live here.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic       PORT_I     = 1'b0;
    localparam logic       PORT_D     = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the port not granted last wins.
// With a single requester that requester wins; with none the output is don't-care.
module rr_arb2
    import mem_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = PORT_I;
        if (req_i && req_d) grant = ~last_grant;
        else if (req_d)     grant = PORT_D;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-cycle sram between an instruction read port and a data
// read/write port. IDLE -> ACCESS -> RESP, ack two cycles after req is sampled.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state, state_nx;
    logic              grant, last_grant;
    logic              win_id, win_we, win_mis;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req, access_go, resp;

    assign any_req = i_req || d_req;

    rr_arb2 u_rr (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (any_req) state_nx = ST_ACCESS;
            ST_ACCESS: state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Requests are sampled only in IDLE; later changes by the requester are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_D;
            win_id     <= PORT_I;
            win_we     <= 1'b0;
            win_mis    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (state == ST_IDLE && any_req) begin
            last_grant <= grant;
            win_id     <= grant;
            win_we     <= (grant == PORT_D) && d_we;
            win_mis    <= is_misaligned((grant == PORT_D) ? d_addr[1:0] : i_addr[1:0]);
            lat_addr   <= (grant == PORT_D) ? d_addr : i_addr;
            lat_wdata  <= ((grant == PORT_D) && d_we) ? d_wdata : '0;
        end
    end

    assign access_go = (state == ST_ACCESS) && !win_mis;
    assign mem_cs    = access_go;
    assign mem_oe    = access_go && !win_we;
    assign mem_we    = access_go && win_we;
    assign mem_addr  = lat_addr;
    assign mem_din   = lat_wdata;

    // Only reads update rdata; writes and misaligned accesses leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (access_go && !win_we) begin
            if (win_id == PORT_D) d_rdata <= mem_dout;
            else                  i_rdata <= mem_dout;
        end
    end

    assign resp  = (state == ST_RESP);
    assign i_ack = resp && (win_id == PORT_I);
    assign d_ack = resp && (win_id == PORT_D);
    assign i_err = i_ack && win_mis;
    assign d_err = d_ack && win_mis;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares them against whatever the DUT acks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, i_err, d_ack, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   rd_strb = 0, wr_strb = 0, cs_cnt = 0;
    logic [31:0] cs_addr = '0, cs_din = '0;

    logic [31:0] sram [0:255];
    logic        preloaded = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Asynchronous-read, synchronous-write sram model.
    assign mem_dout = sram[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int k = 0; k < 256; k++) sram[k] <= '0;
            sram[8'h14] <= 32'h8C08_0004;
            preloaded   <= 1'b1;
        end else if (mem_cs && mem_we) begin
            sram[mem_addr[9:2]] <= mem_din;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_cs) begin cs_cnt++; cs_addr = mem_addr; cs_din = mem_din; end
        if (mem_cs && mem_oe) rd_strb++;
        if (mem_cs && mem_we) wr_strb++;
    end

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every ack.
    always @(negedge clk) begin
        if (rst_n) begin
            check("oe_we_exclusive", !(mem_oe && mem_we), {mem_oe, mem_we}, 32'h0);
            check("acks_exclusive",  !(i_ack && d_ack),   {i_ack, d_ack},   32'h0);
            check("err_without_ack", !((i_err && !i_ack) || (d_err && !d_ack)), {i_err, d_err}, 32'h0);
            if (i_ack || d_ack) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 1'b0, {i_ack, d_ack}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("ack_port", d_ack == e.port, d_ack, e.port);
                    check("ack_rdata", (e.port ? d_rdata : i_rdata) == e.rdata,
                          e.port ? d_rdata : i_rdata, e.rdata);
                    check("ack_err", (e.port ? d_err : i_err) == e.err,
                          e.port ? d_err : i_err, e.err);
                end
            end
        end
    end

    function automatic logic [255:0] all_outs();
        return {i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
                mem_cs, mem_oe, mem_we, mem_addr, mem_din};
    endfunction

    // Single request on one port; checks latency, strobe counts and sram address.
    task automatic do_req(input string name, input logic port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_rd, input int exp_wr);
        int   rd0, wr0, cs0, n;
        logic got;
        @(posedge clk); #1;
        rd0 = rd_strb; wr0 = wr_strb; cs0 = cs_cnt;
        if (port) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else      begin i_req = 1'b1; i_addr = addr; end
        sb_q.push_back('{port, exp_rdata, exp_err});
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++;
            got = port ? d_ack : i_ack;
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        check({name, "_latency"}, got && n == 2, n, 2);
        check({name, "_rd_strobes"}, rd_strb - rd0 == exp_rd, rd_strb - rd0, exp_rd);
        check({name, "_wr_strobes"}, wr_strb - wr0 == exp_wr, wr_strb - wr0, exp_wr);
        check({name, "_cs_cycles"}, cs_cnt - cs0 == exp_rd + exp_wr, cs_cnt - cs0, exp_rd + exp_wr);
        if (exp_rd + exp_wr > 0) check({name, "_mem_addr"}, cs_addr == addr, cs_addr, addr);
        if (exp_wr > 0)          check({name, "_mem_din"},  cs_din == wdata, cs_din, wdata);
    endtask

    // Waits for the next ack of either port, bounded.
    task automatic wait_ack(output logic port, output logic got);
        int n;
        n = 0; got = 1'b0; port = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1; n++;
            if (i_ack || d_ack) begin got = 1'b1; port = d_ack; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic p, g;
        int   acks, last_cyc, n;

        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", all_outs() == '0, all_outs() != '0, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        do_req("i_read",    1'b0, 1'b0, 32'h0040_0050, 32'h0, 32'h8C08_0004, 1'b0, 1, 0);
        do_req("d_write",   1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1);
        check("sram_written", sram[0] == 32'hDEAD_BEEF, sram[0], 32'hDEAD_BEEF);
        do_req("d_read",    1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 0);
        do_req("d_misalign", 1'b1, 1'b0, 32'h1001_0002, 32'h0, 32'hDEAD_BEEF, 1'b1, 0, 0);
        do_req("i_misalign", 1'b0, 1'b0, 32'h0040_0052, 32'h0, 32'h8C08_0004, 1'b1, 0, 0);

        // Contention from reset: I first, then alternating, acks 3 cycles apart.
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0040_0050;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0000;
        for (int k = 0; k < 4; k++)
            sb_q.push_back(k % 2 == 0 ? '{1'b0, 32'h8C08_0004, 1'b0}
                                      : '{1'b1, 32'hDEAD_BEEF, 1'b0});
        acks = 0; last_cyc = 0; n = 0;
        while (acks < 4 && n < 40) begin
            @(posedge clk); #1; n++;
            if (i_ack || d_ack) begin
                check("rr_order", d_ack == logic'(acks % 2), d_ack, acks % 2);
                if (acks > 0) check("rr_spacing", cyc - last_cyc == 3, cyc - last_cyc, 3);
                last_cyc = cyc;
                acks++;
                if (acks == 4) begin i_req = 1'b0; d_req = 1'b0; end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("rr_ack_count", acks == 4, acks, 4);

        // Reset while a D write is in ACCESS: everything drops, no ack, I wins next.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        check("abort_in_access", mem_we && mem_cs, {mem_cs, mem_we}, 32'h3);
        rst_n = 1'b0;
        #1 check("abort_outputs", all_outs() == '0, all_outs() != '0, 32'h0);
        i_req = 1'b1; i_addr = 32'h0040_0050;
        sb_q.push_back('{1'b0, 32'h8C08_0004, 1'b0});
        sb_q.push_back('{1'b1, 32'h0, 1'b0});
        @(negedge clk) rst_n = 1'b1;
        wait_ack(p, g);
        check("post_reset_first", g && p == 1'b0, {g, p}, 32'h2);
        i_req = 1'b0;
        wait_ack(p, g);
        check("post_reset_second", g && p == 1'b1, {g, p}, 32'h3);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        check("sram_rewritten", sram[1] == 32'h1234_5678, sram[1], 32'h1234_5678);

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_req  input  1  instruction-port read request.
REQ-006 SHALL have port i_addr  input  ADDR_W  instruction byte address.
REQ-007 SHALL have port i_ack  output  1  instruction access complete, one-cycle pulse.
REQ-008 SHALL have port i_rdata  output  DATA_W  instruction read data, valid with i_ack.
REQ-009 SHALL have port i_err  output  1  misaligned instruction address, valid with i_ack.
REQ-010 SHALL have port d_req  input  1  data-port request.
REQ-011 SHALL have port d_we  input  1  data-port write (1) or read (0).
REQ-012 SHALL have port d_addr  input  ADDR_W  data byte address.
REQ-013 SHALL have port d_wdata  input  DATA_W  data write value.
REQ-014 SHALL have port d_ack  output  1  data access complete, one-cycle pulse.
REQ-015 SHALL have port d_rdata  output  DATA_W  data read value, valid with d_ack.
REQ-016 SHALL have port d_err  output  1  misaligned data address, valid with d_ack.
REQ-017 SHALL have ports mem_cs, mem_oe, mem_we  output  1 each  shared sram chip-select, read-enable, write-enable.
REQ-018 SHALL have ports mem_addr  output  ADDR_W, mem_din  output  DATA_W, mem_dout  input  DATA_W  sram address, write data, read data.

Function
REQ-019 SHALL arbitrate one sram between both ports with FSM states IDLE, ACCESS, RESP; encoding from the package.
REQ-020 IDLE: no sram strobes; at a rising edge with any req high, SHALL latch the winner's id, address, we and wdata and go to ACCESS.
REQ-021 Both req high in IDLE: SHALL grant the port not granted last (round-robin); last-grant resets to D, so I wins the first contention.
REQ-022 ACCESS lasts exactly one cycle: mem_cs=1, mem_addr=latched address, mem_oe=~we, mem_we=we, mem_din=latched wdata (0 on reads); at its end SHALL capture mem_dout into the winner's rdata and go to RESP.
REQ-023 RESP lasts one cycle: winner's ack=1, sram strobes 0, then SHALL return to IDLE; latency from req sampled to ack is 2 cycles, minimum access period 3 cycles.
REQ-024 Misaligned address (addr[1:0]!=0) SHALL skip sram strobes in ACCESS (mem_cs=0), leave rdata unchanged, and assert err with ack in RESP.
REQ-025 Requester SHALL hold req, addr, we, wdata stable until ack; arbiter only samples them in IDLE, so changes after the grant edge are ignored.
REQ-026 A req still high in the cycle after ack SHALL be treated as a new request in IDLE.
REQ-027 rdata of the non-winning port SHALL hold its previous value; err SHALL be 0 whenever ack is 0.
REQ-028 Only one of i_ack, d_ack SHALL be high in any cycle; mem_oe and mem_we SHALL never both be high.
REQ-029 Port I SHALL never drive mem_we high.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, last-grant D, all strobes, acks, errs, rdata, mem_addr and mem_din to 0.
REQ-031 Reset during ACCESS or RESP SHALL abort the access with no ack; a write in flight is not guaranteed to have completed.

Structure
REQ-032 State encoding, port-id constants (PORT_I, PORT_D) and alignment-mask constant SHALL live in shared package mem_pkg.
REQ-033 Round-robin choice SHALL be a sub-module rr_arb2 (inputs two reqs and last-grant, output grant id).

Verification
REQ-034 I read 0x00400050, sram word 0x8C080004 -> mem_cs=mem_oe=1 one cycle, i_ack 2 cycles after req, i_rdata=0x8C080004.
REQ-035 D write 0x10010000=0xDEADBEEF then D read same -> mem_we=1 one cycle, second d_ack gives d_rdata=0xDEADBEEF.
REQ-036 i_req and d_req both held high from reset -> grants alternate I,D,I,D, each ack 3 cycles apart.
REQ-037 D read 0x10010002 -> mem_cs stays 0, d_ack=1 with d_err=1, d_rdata unchanged.
REQ-038 rst_n low during ACCESS of a D write -> all outputs 0 immediately, no d_ack, next i_req served first.
